// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative shift/BFE unit, shifts left by X then right by Y one bit per clock
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shl_amt,
  input  logic [AMT_W-1:0] shr_amt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, FIN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, result_q, result_d;
  logic [AMT_W-1:0] lcnt_q, lcnt_d, rcnt_q, rcnt_d;
  logic             arith_q, arith_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      result_q <= '0;
      lcnt_q   <= '0;
      rcnt_q   <= '0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      lcnt_q   <= lcnt_d;
      rcnt_q   <= rcnt_d;
      arith_q  <= arith_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    result_d = result_q;
    lcnt_d   = lcnt_q;
    rcnt_d   = rcnt_q;
    arith_d  = arith_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d    = data_in;
        lcnt_d  = shl_amt;
        rcnt_d  = shr_amt;
        arith_d = arith;
        state_d = (shl_amt != '0) ? LEFT : (shr_amt != '0) ? RIGHT : FIN;
      end
      LEFT: begin
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        lcnt_d = lcnt_q - 1'b1;
        if (lcnt_q == AMT_W'(1)) state_d = (rcnt_q != '0) ? RIGHT : FIN;
      end
      RIGHT: begin
        sh_d   = {arith_q & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        rcnt_d = rcnt_q - 1'b1;
        if (rcnt_q == AMT_W'(1)) state_d = FIN;
      end
      default: begin
        result_d = sh_q;
        state_d  = IDLE;
      end
    endcase
  end
  // result must be valid during the done cycle itself, so FIN forwards the shift register
  assign done   = state_q == FIN;
  assign busy   = (state_q == LEFT) || (state_q == RIGHT);
  assign result = done ? sh_q : result_q;
endmodule
